// File: rtl/func_gen_pkg.sv
// Shared constants for the DDS function generator: waveform codes, default
// geometry and the derived quarter-period and full-scale values.
package func_gen_pkg;

    typedef enum logic [2:0] {
        WS_SIN = 3'd0,
        WS_COS = 3'd1,
        WS_SQR = 3'd2,
        WS_TRI = 3'd3,
        WS_SAW = 3'd4
    } wsel_e;

    localparam int DW_DEF = 12;
    localparam int PW_DEF = 24;
    localparam int AW_DEF = 12;
    localparam int GW_DEF = 8;

    localparam int QUARTER_OFF = 2 ** (AW_DEF - 2);
    localparam int FS_MAX      = 2 ** (DW_DEF - 1) - 1;
    localparam int FS_MIN      = -(2 ** (DW_DEF - 1));

    function automatic int quarter_off(int aw);
        return 1 << (aw - 2);
    endfunction

    function automatic int fs_max(int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int fs_min(int dw);
        return -(1 << (dw - 1));
    endfunction

endpackage

// File: rtl/func_gen_dds_if.sv
// Control, configuration and sample-output bundle of the DDS generator.
interface func_gen_dds_if #(
    parameter int DW = 12,
    parameter int PW = 24,
    parameter int AW = 12,
    parameter int GW = 8
);
    logic                 s_en;
    logic                 en;
    logic                 sync_clr;
    logic                 cfg_ld;
    logic [PW-1:0]        ftw;
    logic [AW-1:0]        poff;
    logic [2:0]           wsel;
    logic [GW-1:0]        gain;
    logic signed [DW-1:0] wave;
    logic                 wave_vld;
    logic                 phase_wrap;

    modport master (
        output s_en, en, sync_clr, cfg_ld, ftw, poff, wsel, gain,
        input  wave, wave_vld, phase_wrap
    );

    modport slave (
        input  s_en, en, sync_clr, cfg_ld, ftw, poff, wsel, gain,
        output wave, wave_vld, phase_wrap
    );
endinterface

// File: rtl/func_gen_dds_sin_lut.sv
// Registered-output sine ROM, offset-binary, filled at elaboration from
// round((2^DW-1)/2 * (1 + sin(2*pi*k/2^AW))).
module sin_lut #(
    parameter int AW = 12,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);
    localparam int  DEPTH = 2 ** AW;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = ((2.0 ** DW) - 1.0) / 2.0;

    function automatic logic [DW-1:0] entry(int k);
        real x;
        x = AMP * (1.0 + $sin(2.0 * PI * real'(k) / real'(DEPTH)));
        // x is never negative, so adding one half and truncating rounds half up
        return DW'($rtoi(x + 0.5));
    endfunction

    logic [DW-1:0] rom [DEPTH];
    logic [DW-1:0] data_d;
    logic [DW-1:0] data_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = entry(k);
    end

    always_comb data_d = rom[addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) data_q <= '0;
        else      data_q <= data_d;
    end

    assign data = data_q;
endmodule

// File: rtl/func_gen_dds.sv
// DDS function generator: phase accumulator with shadowed configuration,
// five waveform shapes, rounded and saturated gain, three-stage pipeline.
module func_gen_dds
    import func_gen_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF,
    parameter int GW = GW_DEF
) (
    input logic          clk,
    input logic          rst,
    func_gen_dds_if.slave io
);
    localparam int P1W    = (AW > DW + 1) ? AW : DW + 1;
    localparam int PROD_W = DW + GW + 1;

    localparam logic [AW-1:0]            QTR    = AW'(quarter_off(AW));
    localparam logic signed [DW-1:0]     SQ_POS = DW'(fs_max(DW));
    localparam logic signed [DW-1:0]     SQ_NEG = DW'(-fs_max(DW));
    localparam logic signed [PROD_W-1:0] Y_MAX  = PROD_W'(fs_max(DW));
    localparam logic signed [PROD_W-1:0] Y_MIN  = PROD_W'(fs_min(DW));
    localparam logic signed [PROD_W-1:0] RND    = PROD_W'(2 ** (GW - 2));

    // shadow and active configuration
    logic [PW-1:0] sh_ftw_q, sh_ftw_d;
    logic [AW-1:0] sh_poff_q, sh_poff_d;
    logic [2:0]    sh_wsel_q, sh_wsel_d;
    logic [GW-1:0] sh_gain_q, sh_gain_d;
    logic [AW-1:0] act_poff_q, act_poff_d;
    logic [2:0]    act_wsel_q, act_wsel_d;
    logic [GW-1:0] act_gain_q, act_gain_d;

    logic [PW-1:0] phase_q, phase_d, phase_sum;
    logic          wrap_pend_q, wrap_pend_d;
    logic          accept, carry;

    // S1
    logic [P1W-1:0] p1_q, p1_d;
    logic           v1_q, v1_d, wrap1_q, wrap1_d;

    // S2
    logic                 v2_q, v2_d, wrap2_q, wrap2_d;
    logic [2:0]           wsel2_q, wsel2_d;
    logic [GW-1:0]        gain2_q, gain2_d;
    logic signed [DW-1:0] alt2_q, alt2_d;

    // S3
    logic signed [DW-1:0] wave_q, wave_d;
    logic                 vld_q, vld_d, pwrap_q, pwrap_d;

    logic [AW-1:0]            rom_addr;
    logic [DW-1:0]            rom_data;
    logic                     p_msb;
    logic [DW-1:0]            tri_t;
    logic signed [DW-1:0]     alt_shape, shape, y_sat;
    logic signed [PROD_W-1:0] s_ext, g_ext, prod, y;

    sin_lut #(.AW(AW), .DW(DW)) u_lut (
        .clk  (clk),
        .rst  (rst),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_comb begin
        accept             = io.s_en & io.en & ~io.sync_clr;
        {carry, phase_sum} = {1'b0, phase_q} + {1'b0, sh_ftw_q};

        sh_ftw_d    = sh_ftw_q;
        sh_poff_d   = sh_poff_q;
        sh_wsel_d   = sh_wsel_q;
        sh_gain_d   = sh_gain_q;
        act_poff_d  = act_poff_q;
        act_wsel_d  = act_wsel_q;
        act_gain_d  = act_gain_q;
        phase_d     = phase_q;
        wrap_pend_d = wrap_pend_q;
        p1_d        = p1_q;
        wrap1_d     = wrap1_q;
        v1_d        = accept;

        if (io.cfg_ld) begin
            sh_ftw_d  = io.ftw;
            sh_poff_d = io.poff;
            sh_wsel_d = io.wsel;
            sh_gain_d = io.gain;
        end

        if (io.sync_clr) begin
            phase_d     = '0;
            wrap_pend_d = 1'b1;
        end else if (accept) begin
            // the shadow becomes active on this strobe, so its ftw advances the phase
            act_poff_d  = sh_poff_q;
            act_wsel_d  = sh_wsel_q;
            act_gain_d  = sh_gain_q;
            p1_d        = phase_q[PW-1 -: P1W];
            wrap1_d     = wrap_pend_q;
            phase_d     = phase_sum;
            wrap_pend_d = carry;
        end
    end

    always_comb begin
        p_msb    = p1_q[P1W-1];
        rom_addr = p1_q[P1W-1 -: AW] + act_poff_q + ((act_wsel_q == WS_COS) ? QTR : '0);
        tri_t    = p1_q[P1W-2 -: DW] ^ {DW{p_msb}};

        case (act_wsel_q)
            WS_SQR:  alt_shape = p_msb ? SQ_NEG : SQ_POS;
            WS_TRI:  alt_shape = {~tri_t[DW-1], tri_t[DW-2:0]};
            WS_SAW:  alt_shape = {~p1_q[P1W-1], p1_q[P1W-2 -: DW-1]};
            default: alt_shape = '0;
        endcase

        if (wsel2_q == WS_SIN || wsel2_q == WS_COS) shape = {~rom_data[DW-1], rom_data[DW-2:0]};
        else                                          shape = alt2_q;

        s_ext = {{(GW + 1){shape[DW-1]}}, shape};
        g_ext = {{(DW + 1){1'b0}}, gain2_q};
        prod  = s_ext * g_ext;
        y     = (prod + RND) >>> (GW - 1);

        if (y > Y_MAX)      y_sat = Y_MAX[DW-1:0];
        else if (y < Y_MIN) y_sat = Y_MIN[DW-1:0];
        else                y_sat = y[DW-1:0];

        v2_d    = v1_q & ~io.sync_clr;
        wrap2_d = wrap2_q;
        wsel2_d = wsel2_q;
        gain2_d = gain2_q;
        alt2_d  = alt2_q;
        if (v1_q) begin
            wrap2_d = wrap1_q;
            wsel2_d = act_wsel_q;
            gain2_d = act_gain_q;
            alt2_d  = alt_shape;
        end

        vld_d   = v2_q & ~io.sync_clr;
        pwrap_d = v2_q & wrap2_q & ~io.sync_clr;
        wave_d  = wave_q;
        if (io.sync_clr)  wave_d = '0;
        else if (v2_q)    wave_d = y_sat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_ftw_q    <= '0;
            sh_poff_q   <= '0;
            sh_wsel_q   <= '0;
            sh_gain_q   <= '0;
            act_poff_q  <= '0;
            act_wsel_q  <= '0;
            act_gain_q  <= '0;
            phase_q     <= '0;
            wrap_pend_q <= 1'b1;
            p1_q        <= '0;
            v1_q        <= 1'b0;
            wrap1_q     <= 1'b0;
            v2_q        <= 1'b0;
            wrap2_q     <= 1'b0;
            wsel2_q     <= '0;
            gain2_q     <= '0;
            alt2_q      <= '0;
            wave_q      <= '0;
            vld_q       <= 1'b0;
            pwrap_q     <= 1'b0;
        end else begin
            sh_ftw_q    <= sh_ftw_d;
            sh_poff_q   <= sh_poff_d;
            sh_wsel_q   <= sh_wsel_d;
            sh_gain_q   <= sh_gain_d;
            act_poff_q  <= act_poff_d;
            act_wsel_q  <= act_wsel_d;
            act_gain_q  <= act_gain_d;
            phase_q     <= phase_d;
            wrap_pend_q <= wrap_pend_d;
            p1_q        <= p1_d;
            v1_q        <= v1_d;
            wrap1_q     <= wrap1_d;
            v2_q        <= v2_d;
            wrap2_q     <= wrap2_d;
            wsel2_q     <= wsel2_d;
            gain2_q     <= gain2_d;
            alt2_q      <= alt2_d;
            wave_q      <= wave_d;
            vld_q       <= vld_d;
            pwrap_q     <= pwrap_d;
        end
    end

    assign io.wave       = wave_q;
    assign io.wave_vld   = vld_q;
    assign io.phase_wrap = pwrap_q;
endmodule

// File: tb/tb_func_gen_dds.sv
// Scoreboard bench for func_gen_dds: directed strobes push hand-computed
// samples, a negedge monitor pops and compares on every wave_vld.
module tb_func_gen_dds;
    import func_gen_pkg::*;

    localparam int DW = 12;
    localparam int PW = 24;
    localparam int AW = 12;
    localparam int GW = 8;

    localparam logic [PW-1:0] F20 = 24'h100000;
    localparam logic [PW-1:0] F21 = 24'h200000;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic clk_run = 1'b1;
    logic mon_en  = 1'b1;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    func_gen_dds_if #(.DW(DW), .PW(PW), .AW(AW), .GW(GW)) io ();

    func_gen_dds #(.DW(DW), .PW(PW), .AW(AW), .GW(GW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    typedef struct {
        logic chk;
        int   wave;
        logic wrap;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   mon_idx = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    int saw255[17] = '{-2048, -2048, -2048, -2048, -2040, -1530, -1020, -510,
                       0, 510, 1020, 1530, 2040, 2047, 2047, 2047, -2048};
    int tri8[8]    = '{-2048, -1024, 0, 1024, 2047, 1023, -1, -1025};
    int cos_q[3]   = '{2047, 0, -2048};

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst && io.wave_vld) begin
            if (sb.size() == 0) begin
                check($sformatf("unexpected_valid[%0d]", mon_idx), 1, 0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.chk) check($sformatf("wave[%0d]", mon_idx), int'(io.wave), mon_e.wave);
                check($sformatf("phase_wrap[%0d]", mon_idx), int'(io.phase_wrap), int'(mon_e.wrap));
            end
            mon_idx++;
        end
        if (mon_en && rst && !io.wave_vld && io.phase_wrap)
            check("wrap_without_valid", 1, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (5) tick();
    endtask

    task automatic load_cfg(input logic [PW-1:0] f, input logic [2:0] w, input logic [GW-1:0] g);
        io.ftw    = f;
        io.wsel   = w;
        io.gain   = g;
        io.poff   = '0;
        io.cfg_ld = 1'b1;
        tick();
        io.cfg_ld = 1'b0;
    endtask

    task automatic clear();
        io.sync_clr = 1'b1;
        tick();
        io.sync_clr = 1'b0;
    endtask

    task automatic strobe(input logic chk, input int w, input logic wr);
        sb.push_back('{chk, w, wr});
        io.s_en = 1'b1;
        tick();
        io.s_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        io.s_en = 1'b0; io.en = 1'b1; io.sync_clr = 1'b0; io.cfg_ld = 1'b0;
        io.ftw = '0; io.poff = '0; io.wsel = '0; io.gain = '0;
        #12;
        check("rst_wave", int'(io.wave), 0);
        check("rst_vld", int'(io.wave_vld), 0);
        check("rst_wrap", int'(io.phase_wrap), 0);
        rst = 1'b1;
        tick();

        // square, first-sample latency, then the repeating 8/8 pattern
        load_cfg(F20, WS_SQR, 8'd128);
        sb.push_back('{1'b1, 2047, 1'b1});
        io.s_en = 1'b1;
        tick();
        io.s_en = 1'b0;
        check("lat_cycle1", int'(io.wave_vld), 0);
        tick();
        check("lat_cycle2", int'(io.wave_vld), 0);
        tick();
        check("lat_cycle3", int'(io.wave_vld), 1);
        for (int i = 1; i < 32; i++)
            strobe(1'b1, ((i % 16) < 8) ? 2047 : -2047, (i % 16) == 0);
        drain();

        // cosine at unity gain, then half gain
        load_cfg(F20, WS_COS, 8'd128);
        clear();
        for (int i = 0; i < 9; i++)
            strobe((i % 4) == 0, cos_q[i / 4], i == 0);
        drain();
        load_cfg(F20, WS_COS, 8'd64);
        clear();
        strobe(1'b1, 1024, 1'b1);
        drain();

        // saturation: square and sawtooth at gain 255
        load_cfg(F20, WS_SQR, 8'd255);
        clear();
        for (int i = 0; i < 16; i++)
            strobe(1'b1, (i < 8) ? 2047 : -2048, i == 0);
        drain();
        load_cfg(F20, WS_SAW, 8'd255);
        clear();
        for (int i = 0; i < 17; i++)
            strobe(1'b1, saw255[i], (i % 16) == 0);
        drain();

        // triangle
        load_cfg(F21, WS_TRI, 8'd128);
        clear();
        for (int i = 0; i < 16; i++)
            strobe(1'b1, tri8[i % 8], (i % 8) == 0);
        drain();

        // cfg_ld together with a strobe: new shape only from the next strobe
        clear();
        io.ftw = F21; io.wsel = WS_SAW; io.gain = 8'd128; io.cfg_ld = 1'b1;
        strobe(1'b1, -2048, 1'b1);
        io.cfg_ld = 1'b0;
        strobe(1'b1, -1536, 1'b0);
        strobe(1'b1, -1024, 1'b0);
        drain();

        // sync_clr drops the simultaneous strobe and restarts at p=0
        io.sync_clr = 1'b1;
        io.s_en     = 1'b1;
        tick();
        io.s_en     = 1'b0;
        io.sync_clr = 1'b0;
        check("clr_wave", int'(io.wave), 0);
        check("clr_vld", int'(io.wave_vld), 0);
        drain();
        strobe(1'b1, -2048, 1'b1);
        drain();

        // en low: strobes ignored, phase frozen, wave held
        io.en   = 1'b0;
        io.s_en = 1'b1;
        repeat (5) tick();
        io.s_en = 1'b0;
        io.en   = 1'b1;
        drain();
        check("en_low_hold", int'(io.wave), -2048);
        strobe(1'b1, -1536, 1'b0);
        drain();

        // asynchronous reset mid-stream with the clock stopped
        mon_en  = 1'b0;
        io.s_en = 1'b1;
        repeat (4) tick();
        check("pre_rst_vld", int'(io.wave_vld), 1);
        check("pre_rst_wave", int'(io.wave), -512);
        clk_run = 1'b0;
        #20;
        rst = 1'b0;
        #1;
        check("async_rst_wave", int'(io.wave), 0);
        check("async_rst_vld", int'(io.wave_vld), 0);
        check("async_rst_wrap", int'(io.phase_wrap), 0);
        io.s_en = 1'b0;
        #5;
        rst = 1'b1;
        sb.delete();
        clk_run = 1'b1;
        mon_en  = 1'b1;
        tick();
        load_cfg(F20, WS_SQR, 8'd128);
        strobe(1'b1, 2047, 1'b1);
        drain();

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
